// File: rtl/proj3_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// proj3_stream_arbiter_if
//
// One symbol-stream requester link between a stimulus source and the
// stream arbiter. A symbol moves on a cycle where valid and ready are both
// high.
//
//   valid : source has a symbol on sym this cycle
//   sym   : 2-bit symbol {x1,x0} destined for the sequence detector
//   last  : sym is the final symbol of the packet (qualified by valid)
//   ready : arbiter accepts the symbol this cycle
//
// Modports:
//   master : the symbol source (drives valid/sym/last, observes ready)
//   slave  : the arbiter side (observes valid/sym/last, drives ready)
// ---------------------------------------------------------------------------
interface proj3_stream_arbiter_if;

    logic       valid;
    logic [1:0] sym;
    logic       last;
    logic       ready;

    modport master (
        output valid,
        output sym,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  sym,
        input  last,
        output ready
    );

endinterface : proj3_stream_arbiter_if

// File: rtl/proj3_stream_arbiter.sv
// ---------------------------------------------------------------------------
// proj3_stream_arbiter
//
// Shares a single two-bit-input sequence detector between two symbol-stream
// requesters. A requester owns the detector for a whole packet; ownership is
// decided round-robin when both ask at once. Before every packet the detector
// is cleared for one cycle, then the owner's symbols are forwarded one per
// cycle. Accepted symbols and detector z1/z0 hits are counted (saturating) and
// reported with a one-cycle done pulse after the last symbol.
//
// Parameters:
//   CW          : width of the three saturating result counters
//
// Ports:
//   clk         : rising-edge clock
//   r           : synchronous active-low reset
//   req_a       : requester A stream (slave side)
//   req_b       : requester B stream (slave side)
//   det_x1/x0   : detector symbol inputs (00 is the detector hold symbol)
//   det_r       : detector clear, active-high
//   det_z1/z0   : detector outputs, valid in the same cycle as det_x1/x0
//   done        : one-cycle packet-complete pulse
//   done_id     : packet owner while done=1 (0 = A, 1 = B)
//   sym_count   : accepted symbols in the packet, valid while done=1
//   z1_count    : accepted symbols with det_z1=1, valid while done=1
//   z0_count    : accepted symbols with det_z0=1, valid while done=1
// ---------------------------------------------------------------------------
module proj3_stream_arbiter #(
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   r,
    proj3_stream_arbiter_if.slave  req_a,
    proj3_stream_arbiter_if.slave  req_b,
    output logic                   det_x1,
    output logic                   det_x0,
    output logic                   det_r,
    input  logic                   det_z1,
    input  logic                   det_z0,
    output logic                   done,
    output logic                   done_id,
    output logic [CW-1:0]          sym_count,
    output logic [CW-1:0]          z1_count,
    output logic [CW-1:0]          z0_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt,
                                              input logic          inc);
        logic [CW-1:0] res;
        if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CW'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_t        state_q,      state_d;
    logic          grant_q,      grant_d;       // 0 = A, 1 = B
    logic          last_grant_q, last_grant_d;  // owner of the previous packet
    logic [CW-1:0] sym_cnt_q,    sym_cnt_d;
    logic [CW-1:0] z1_cnt_q,     z1_cnt_d;
    logic [CW-1:0] z0_cnt_q,     z0_cnt_d;

    logic          g_valid_s;
    logic [1:0]    g_sym_s;
    logic          g_last_s;
    logic          accept_s;

    // Select the granted requester's stream; the other one is never looked at
    // while streaming.
    always_comb begin
        if (grant_q) begin
            g_valid_s = req_b.valid;
            g_sym_s   = req_b.sym;
            g_last_s  = req_b.last;
        end else begin
            g_valid_s = req_a.valid;
            g_sym_s   = req_a.sym;
            g_last_s  = req_a.last;
        end
        accept_s = (state_q == ST_STREAM) && g_valid_s;
    end

    // Next-state, grant and counter update logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sym_cnt_d    = sym_cnt_q;
        z1_cnt_d     = z1_cnt_q;
        z0_cnt_d     = z0_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Contention goes to whoever did not own the previous packet.
                if (req_a.valid && req_b.valid) begin
                    grant_d = ~last_grant_q;
                    state_d = ST_CLEAR;
                end else if (req_a.valid) begin
                    grant_d = 1'b0;
                    state_d = ST_CLEAR;
                end else if (req_b.valid) begin
                    grant_d = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                sym_cnt_d = CNT_ZERO;
                z1_cnt_d  = CNT_ZERO;
                z0_cnt_d  = CNT_ZERO;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                // z hits only count on cycles where a symbol was really fed in.
                if (accept_s) begin
                    sym_cnt_d = sat_inc(sym_cnt_q, 1'b1);
                    z1_cnt_d  = sat_inc(z1_cnt_q, det_z1);
                    z0_cnt_d  = sat_inc(z0_cnt_q, det_z0);
                    if (g_last_s) begin
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_REPORT: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset leaves B as the previous owner so
    // the first contended grant after reset goes to A.
    always_ff @(posedge clk) begin
        if (!r) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            sym_cnt_q    <= CNT_ZERO;
            z1_cnt_q     <= CNT_ZERO;
            z0_cnt_q     <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sym_cnt_q    <= sym_cnt_d;
            z1_cnt_q     <= z1_cnt_d;
            z0_cnt_q     <= z0_cnt_d;
        end
    end

    // Handshake and detector drive. Everything is forced quiet while r=0,
    // except det_r which holds the detector cleared during reset.
    assign req_a.ready = r && (state_q == ST_STREAM) && !grant_q;
    assign req_b.ready = r && (state_q == ST_STREAM) &&  grant_q;
    assign det_x1      = r && accept_s && g_sym_s[1];
    assign det_x0      = r && accept_s && g_sym_s[0];
    assign det_r       = !r || (state_q == ST_CLEAR);

    // Report outputs are decoded from state or taken straight from registers.
    assign done        = r && (state_q == ST_REPORT);
    assign done_id     = r && grant_q;
    assign sym_count   = sym_cnt_q;
    assign z1_count    = z1_cnt_q;
    assign z0_count    = z0_cnt_q;

endmodule : proj3_stream_arbiter

// File: tb/tb_proj3_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_proj3_stream_arbiter
//
// Two arbiters (CW=8 and CW=2) receive identical stimulus; the bench plays
// the detector stub by driving det_z1/det_z0 directly. Directed cycles come
// from a table of {inputs, expected outputs}; a randomized run follows,
// checked against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_proj3_stream_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r, a_valid, a_last, b_valid, b_last, z1, z0;
    logic [1:0] a_sym, b_sym;

    proj3_stream_arbiter_if if_a8 ();
    proj3_stream_arbiter_if if_b8 ();
    proj3_stream_arbiter_if if_a2 ();
    proj3_stream_arbiter_if if_b2 ();

    assign if_a8.valid = a_valid;
    assign if_a8.sym   = a_sym;
    assign if_a8.last  = a_last;
    assign if_b8.valid = b_valid;
    assign if_b8.sym   = b_sym;
    assign if_b8.last  = b_last;
    assign if_a2.valid = a_valid;
    assign if_a2.sym   = a_sym;
    assign if_a2.last  = a_last;
    assign if_b2.valid = b_valid;
    assign if_b2.sym   = b_sym;
    assign if_b2.last  = b_last;

    logic       x1_8, x0_8, dr_8, done_8, id_8;
    logic [7:0] sc_8, c1_8, c0_8;
    logic       x1_2, x0_2, dr_2, done_2, id_2;
    logic [1:0] sc_2, c1_2, c0_2;

    proj3_stream_arbiter #(.CW(8)) u_dut8 (
        .clk(clk), .r(r), .req_a(if_a8), .req_b(if_b8),
        .det_x1(x1_8), .det_x0(x0_8), .det_r(dr_8),
        .det_z1(z1), .det_z0(z0),
        .done(done_8), .done_id(id_8),
        .sym_count(sc_8), .z1_count(c1_8), .z0_count(c0_8)
    );

    proj3_stream_arbiter #(.CW(2)) u_dut2 (
        .clk(clk), .r(r), .req_a(if_a2), .req_b(if_b2),
        .det_x1(x1_2), .det_x0(x0_2), .det_r(dr_2),
        .det_z1(z1), .det_z0(z0),
        .done(done_2), .done_id(id_2),
        .sym_count(sc_2), .z1_count(c1_2), .z0_count(c0_2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int r, av, as, al, bv, bs, bl, z1, z0;      // inputs
        int ra, rb, x, dr, dn, id, cc, s, c1, c0;   // expected (raw counts)
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int r_i, int av, int as, int al, int bv, int bs, int bl,
                                int zz1, int zz0, int ra, int rb, int x, int dr, int dn,
                                int id, int cc, int s, int c1, int c0);
        vec_t v;
        v.r = r_i; v.av = av; v.as = as; v.al = al; v.bv = bv; v.bs = bs; v.bl = bl;
        v.z1 = zz1; v.z0 = zz0; v.ra = ra; v.rb = rb; v.x = x; v.dr = dr; v.dn = dn;
        v.id = id; v.cc = cc; v.s = s; v.c1 = c1; v.c0 = c0;
        return v;
    endfunction

    // Saturate an unbounded count to a w-bit counter.
    function automatic int satc(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int ra, input int rb, input int x,
                            input int dr, input int dn, input int id, input int cc,
                            input int s, input int c1, input int c0);
        chk({tag, " ready_a8"}, int'(if_a8.ready), ra);
        chk({tag, " ready_b8"}, int'(if_b8.ready), rb);
        chk({tag, " det_x8"},   int'({x1_8, x0_8}), x);
        chk({tag, " det_r8"},   int'(dr_8), dr);
        chk({tag, " done8"},    int'(done_8), dn);
        chk({tag, " ready_a2"}, int'(if_a2.ready), ra);
        chk({tag, " ready_b2"}, int'(if_b2.ready), rb);
        chk({tag, " det_x2"},   int'({x1_2, x0_2}), x);
        chk({tag, " det_r2"},   int'(dr_2), dr);
        chk({tag, " done2"},    int'(done_2), dn);
        if (dn != 0) begin
            chk({tag, " done_id8"}, int'(id_8), id);
            chk({tag, " done_id2"}, int'(id_2), id);
        end
        if (cc != 0) begin
            chk({tag, " sym_count8"}, int'(sc_8), satc(s, 8));
            chk({tag, " z1_count8"},  int'(c1_8), satc(c1, 8));
            chk({tag, " z0_count8"},  int'(c0_8), satc(c0, 8));
            chk({tag, " sym_count2"}, int'(sc_2), satc(s, 2));
            chk({tag, " z1_count2"},  int'(c1_2), satc(c1, 2));
            chk({tag, " z0_count2"},  int'(c0_2), satc(c0, 2));
        end
    endtask

    task automatic drive(input int r_i, input int av, input int as, input int al,
                         input int bv, input int bs, input int bl,
                         input int zz1, input int zz0);
        @(negedge clk);
        r       = (r_i != 0);
        a_valid = (av != 0);
        a_sym   = 2'(as);
        a_last  = (al != 0);
        b_valid = (bv != 0);
        b_sym   = 2'(bs);
        b_last  = (bl != 0);
        z1      = (zz1 != 0);
        z0      = (zz0 != 0);
        #1;
    endtask

    // Reference model: packet phase, owner, previous owner, unbounded tallies.
    int m_ph, m_own, m_prev, m_n, m_z1, m_z0;

    task automatic model_step(output int ra, output int rb, output int x, output int dr,
                              output int dn, output int id, output int s,
                              output int c1, output int c0);
        int gv, gl, gs;
        ra = 0; rb = 0; x = 0; dr = 0; dn = 0; id = 0;
        s = m_n; c1 = m_z1; c0 = m_z0;
        if (!r) begin
            dr = 1;
            m_ph = 0; m_prev = 1; m_n = 0; m_z1 = 0; m_z0 = 0;
        end else if (m_ph == 0) begin
            if (a_valid || b_valid) begin
                if (a_valid && b_valid) m_own = 1 - m_prev;
                else                    m_own = a_valid ? 0 : 1;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            dr = 1;
            m_n = 0; m_z1 = 0; m_z0 = 0;
            m_ph = 2;
        end else if (m_ph == 2) begin
            gv = (m_own == 1) ? int'(b_valid) : int'(a_valid);
            gl = (m_own == 1) ? int'(b_last)  : int'(a_last);
            gs = (m_own == 1) ? int'(b_sym)   : int'(a_sym);
            if (m_own == 1) rb = 1;
            else            ra = 1;
            if (gv != 0) begin
                x = gs;
                m_n++;
                m_z1 += int'(z1);
                m_z0 += int'(z0);
                if (gl != 0) m_ph = 3;
            end
        end else begin
            dn = 1; id = m_own;
            m_prev = m_own;
            m_ph = 0;
        end
    endtask

    initial begin
        int ra, rb, x, dr, dn, id, s, c1, c0;
        r = 1'b0; a_valid = 1'b0; a_sym = 2'b00; a_last = 1'b0;
        b_valid = 1'b0; b_sym = 2'b00; b_last = 1'b0; z1 = 1'b0; z0 = 1'b0;
        m_ph = 0; m_own = 0; m_prev = 1; m_n = 0; m_z1 = 0; m_z0 = 0;

        //             r av as al bv bs bl z1 z0  ra rb x dr dn id cc  s c1 c0
        // reset with both valid
        tbl.push_back(mk(0, 1, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        // contention: A first; A packet 01,01,11 with scripted z; B last ignored
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 1,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 2, 0, 1, 1,  1, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 3, 1, 2));
        // B packet, A's symbols ignored while B owns the detector
        tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 2, 0, 0, 0,  0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 1, 2, 1, 1, 0,  0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 2, 1, 0));
        // both request again: A; gaps of 2 with z1 held and a stray last
        tbl.push_back(mk(1, 1, 2, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 1, 0,  1, 0, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3, 1, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3, 1, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 0, 0, 0, 1, 0,  1, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 2, 2, 0));
        // saturation: 5 symbols with z1=1
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 5, 5, 0));
        // single-symbol packet from B
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 1, 1, 0, 1));
        // mid-stream reset after 2 of 4 symbols; next contended grant is A
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 1, 2, 0, 0, 0,  1, 0, 2, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 1, 1, 2, 0, 0, 0,  1, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Directed table; the model is stepped alongside to stay in sync.
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].av, tbl[i].as, tbl[i].al,
                  tbl[i].bv, tbl[i].bs, tbl[i].bl, tbl[i].z1, tbl[i].z0);
            model_step(ra, rb, x, dr, dn, id, s, c1, c0);
            chk_outs($sformatf("vec%0d", i), tbl[i].ra, tbl[i].rb, tbl[i].x,
                     tbl[i].dr, tbl[i].dn, tbl[i].id, tbl[i].cc,
                     tbl[i].s, tbl[i].c1, tbl[i].c0);
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 149) != 0) ? 1 : 0,
                  ($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  ($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            model_step(ra, rb, x, dr, dn, id, s, c1, c0);
            chk_outs($sformatf("rnd%0d", c), ra, rb, x, dr, dn, id, dn, s, c1, c0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_proj3_stream_arbiter
